// File: rtl/laser_arbiter_if.sv
// laser_arbiter_if: request/grant/laser bundle between the requesters and laser_arbiter.
// Abort exists only when LASER_ARB_ABORT_EN is defined.
interface laser_arbiter_if #(
    parameter int N = 4
);
    logic [N-1:0] Req;
    logic         X;
    logic [N-1:0] Gnt;
    logic         Busy;
    logic         Done;

`ifdef LASER_ARB_ABORT_EN
    logic         Abort;

    modport master (output Req, output Abort, input X, input Gnt, input Busy, input Done);
    modport slave  (input Req, input Abort, output X, output Gnt, output Busy, output Done);
`else
    modport master (output Req, input X, input Gnt, input Busy, input Done);
    modport slave  (input Req, output X, output Gnt, output Busy, output Done);
`endif
endinterface

// File: rtl/laser_arbiter.sv
// laser_arbiter: round-robin owner of one laser; fixed PULSE on-time, then COOL off-time per grant.
// Define LASER_ARB_ABORT_EN to add the Abort input that cuts a pulse short.
module laser_arbiter #(
    parameter int N     = 4,
    parameter int PULSE = 3,
    parameter int COOL  = 2,
    parameter int CW    = 8
) (
    input  logic           Clk,
    input  logic           Rst,
    laser_arbiter_if.slave bus
);
    localparam int            IW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] PULSE_LD = CW'(PULSE - 1);
    localparam logic [CW-1:0] COOL_LD  = (COOL > 0) ? CW'(COOL - 1) : '0;
    localparam logic [IW-1:0] LAST_RST = IW'(N - 1);

    typedef enum logic [1:0] {S_IDLE, S_FIRE, S_COOL} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [IW-1:0] last;
    logic [N-1:0]  gnt;
    logic          x;
    logic          busy;
    logic          done;

    logic          pick_valid;
    logic [IW-1:0] pick_idx;
    logic [IW-1:0] cand;
    logic [N-1:0]  pick_onehot;
    logic          abort_hit;

`ifdef LASER_ARB_ABORT_EN
    assign abort_hit = bus.Abort;
`else
    assign abort_hit = 1'b0;
`endif

    // Scan from the farthest candidate back to last+1 so the nearest set bit is the one kept.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        pick_valid  = 1'b0;
        pick_idx    = '0;
        cand        = '0;
        for (int k = N; k >= 1; k--) begin
            cand = IW'((int'(last) + k) % N);
            if (bus.Req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
        pick_onehot           = '0;
        pick_onehot[pick_idx] = 1'b1;
    end

    // NOTE: all state and outputs use non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            last  <= LAST_RST;
            gnt   <= '0;
            x     <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (pick_valid) begin
                        state <= S_FIRE;
                        cnt   <= PULSE_LD;
                        last  <= pick_idx;
                        gnt   <= pick_onehot;
                        x     <= 1'b1;
                        busy  <= 1'b1;
                        done  <= (PULSE == 1);
                    end
                end
                S_FIRE: begin
                    if (cnt == '0 || abort_hit) begin
                        x   <= 1'b0;
                        gnt <= '0;
                        if (COOL > 0) begin
                            state <= S_COOL;
                            cnt   <= COOL_LD;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt  <= cnt - CW'(1);
                        // Raise Done so it lands on the cycle where the counter reads zero.
                        done <= (cnt == CW'(1));
                    end
                end
                S_COOL: begin
                    if (cnt == '0) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    x     <= 1'b0;
                    gnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.X    = x;
    assign bus.Gnt  = gnt;
    assign bus.Busy = busy;
    assign bus.Done = done;
endmodule

// File: tb/tb_laser_arbiter.sv
// tb_laser_arbiter: vector table, directed corner sequences and random traffic against a timeline model.
// Covers both the default build and LASER_ARB_ABORT_EN.
module tb_laser_arbiter;
    localparam int N     = 4;
    localparam int PULSE = 3;
    localparam int COOL  = 2;

    logic Clk;
    logic Rst;

    laser_arbiter_if #(.N(N)) ifc  ();
    laser_arbiter_if #(.N(N)) ifc0 ();

    laser_arbiter #(.N(N), .PULSE(PULSE), .COOL(COOL), .CW(8)) dut  (.Clk(Clk), .Rst(Rst), .bus(ifc.slave));
    laser_arbiter #(.N(N), .PULSE(PULSE), .COOL(0),    .CW(8)) dut0 (.Clk(Clk), .Rst(Rst), .bus(ifc0.slave));

    int n_checks = 0;
    int n_fail   = 0;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    typedef struct {
        logic         rst;
        logic [N-1:0] req;
        logic         x;
        logic [N-1:0] gnt;
        logic         busy;
        logic         done;
    } vec_t;

    typedef struct {
        logic         x;
        logic [N-1:0] gnt;
        logic         busy;
        logic         done;
    } out_t;

    // Timeline model: a grant at edge `start` owns the laser for edges start..start+PULSE-1,
    // cools until next-1, and the next arbitration happens at edge `next`.
    typedef struct {
        int e;
        int last;
        int owner;
        int start;
        int fire_end;
        int next;
    } model_t;

    function automatic model_t model_edge(model_t s, logic [N-1:0] req, logic rst, logic abort, int cool);
        model_t r;
        int     j;
        r   = s;
        r.e = s.e + 1;
        if (rst) begin
            r.last     = N - 1;
            r.start    = -1000;
            r.fire_end = -1000;
            r.next     = r.e + 1;
        end else if (abort && (r.e - 1 >= r.start) && (r.e - 1 < r.fire_end) && (r.e < r.start + PULSE)) begin
            r.fire_end = r.e;
            r.next     = r.e + cool + 1;
        end else if (r.e >= r.next && req != '0) begin
            for (int k = 1; k <= N; k++) begin
                j = (r.last + k) % N;
                if (req[j]) begin
                    r.owner = j;
                    break;
                end
            end
            r.last     = r.owner;
            r.start    = r.e;
            r.fire_end = r.e + PULSE;
            r.next     = r.e + PULSE + cool + 1;
        end
        return r;
    endfunction

    function automatic out_t model_out(model_t s);
        out_t o;
        o.x    = (s.e >= s.start) && (s.e < s.fire_end);
        o.gnt  = o.x ? (N'(1) << s.owner) : '0;
        o.busy = (s.e >= s.start) && (s.e < s.next - 1);
        o.done = (s.e == s.start + PULSE - 1) && (s.fire_end == s.start + PULSE);
        return o;
    endfunction

    model_t m_main = '{e: 0, last: N - 1, owner: 0, start: -1000, fire_end: -1000, next: 0};
    model_t m_zero = '{e: 0, last: N - 1, owner: 0, start: -1000, fire_end: -1000, next: 0};
    logic   abort_main;
    logic   abort_zero;

`ifdef LASER_ARB_ABORT_EN
    assign abort_main = ifc.Abort;
    assign abort_zero = ifc0.Abort;
`else
    assign abort_main = 1'b0;
    assign abort_zero = 1'b0;
`endif

    always @(posedge Clk) begin
        m_main <= model_edge(m_main, ifc.Req,  Rst, abort_main, COOL);
        m_zero <= model_edge(m_zero, ifc0.Req, Rst, abort_zero, 0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_out(input string tag, input out_t exp, input logic x, input logic [N-1:0] gnt,
                             input logic busy, input logic done);
        check({tag, "_x"},    32'(x),    32'(exp.x));
        check({tag, "_gnt"},  32'(gnt),  32'(exp.gnt));
        check({tag, "_busy"}, 32'(busy), 32'(exp.busy));
        check({tag, "_done"}, 32'(done), 32'(exp.done));
    endtask

    task automatic tick();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic set_abort(input logic v);
`ifdef LASER_ARB_ABORT_EN
        ifc.Abort  = v;
        ifc0.Abort = 1'b0;
`else
        if (v) $display("note: abort requested in a build without Abort");
`endif
    endtask

    task automatic do_reset();
        Rst      = 1'b1;
        ifc.Req  = '0;
        ifc0.Req = '0;
        set_abort(1'b0);
        tick();
        tick();
        Rst = 1'b0;
    endtask

    initial begin
        vec_t         vecs[15];
        out_t         exp_o;
        logic [N-1:0] gseq[$];
        logic [N-1:0] exp3[3];
        logic [N-1:0] zgnt[8];
        logic         zx[8];
        logic         px;
        int           plen, gap, bad_len, bad_gap, pulses;
        bit           seen;

        Rst      = 1'b1;
        ifc.Req  = '0;
        ifc0.Req = '0;
        set_abort(1'b0);

        // Reset with all requests high, first grant after release, then a lone 1-cycle request.
        vecs[0]  = '{1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 4'b0000, 1'b1, 4'b0001, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 4'b0000, 1'b1, 4'b0001, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 4'b1000, 1'b1, 4'b0100, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 4'b0000, 1'b1, 4'b0100, 1'b1, 1'b1};
        vecs[11] = '{1'b0, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0};

        for (int i = 0; i < 15; i++) begin
            Rst     = vecs[i].rst;
            ifc.Req = vecs[i].req;
            tick();
            exp_o = '{vecs[i].x, vecs[i].gnt, vecs[i].busy, vecs[i].done};
            check_out($sformatf("vec%0d", i), exp_o, ifc.X, ifc.Gnt, ifc.Busy, ifc.Done);
        end

        // Fairness: all requests held for 40 cycles.
        do_reset();
        ifc.Req = 4'b1111;
        px = 1'b0; plen = 0; gap = 0; bad_len = 0; bad_gap = 0; pulses = 0; seen = 1'b0;
        gseq.delete();
        for (int c = 0; c < 40; c++) begin
            tick();
            if (ifc.X) begin
                if (!px) begin
                    gseq.push_back(ifc.Gnt);
                    if (seen && gap != 3) bad_gap++;
                    seen = 1'b1;
                end
                plen++;
                gap = 0;
            end else begin
                if (px) begin
                    pulses++;
                    if (plen != PULSE) bad_len++;
                    plen = 0;
                end
                gap++;
            end
            px = ifc.X;
        end
        check("fair_pulses", 32'(pulses >= 5), 32'd1);
        for (int i = 0; i < 5; i++)
            check($sformatf("fair_gnt%0d", i), 32'(i < gseq.size() ? gseq[i] : '0), 32'(N'(1) << (i % N)));
        check("fair_bad_len", 32'(bad_len), 32'd0);
        check("fair_bad_gap", 32'(bad_gap), 32'd0);

        // Simultaneous 1 and 3, then requester 0 raised during requester 1's pulse.
        do_reset();
        ifc.Req = 4'b1010;
        exp3[0] = 4'b0010; exp3[1] = 4'b1000; exp3[2] = 4'b0001;
        gseq.delete();
        px = 1'b0;
        for (int c = 0; c < 30 && gseq.size() < 3; c++) begin
            tick();
            if (ifc.X && !px) begin
                gseq.push_back(ifc.Gnt);
                if (gseq.size() == 1) ifc.Req = 4'b1011;
            end
            px = ifc.X;
        end
        check("simul_count", 32'(gseq.size()), 32'd3);
        for (int i = 0; i < 3; i++)
            check($sformatf("simul_gnt%0d", i), 32'(i < gseq.size() ? gseq[i] : '0), 32'(exp3[i]));

        // Zero cooldown instance: two requesters alternate with a single IDLE cycle between pulses.
        do_reset();
        ifc0.Req = 4'b0011;
        zx[0] = 1'b1; zx[1] = 1'b1; zx[2] = 1'b1; zx[3] = 1'b0;
        zx[4] = 1'b1; zx[5] = 1'b1; zx[6] = 1'b1; zx[7] = 1'b0;
        zgnt[0] = 4'b0001; zgnt[1] = 4'b0001; zgnt[2] = 4'b0001; zgnt[3] = 4'b0000;
        zgnt[4] = 4'b0010; zgnt[5] = 4'b0010; zgnt[6] = 4'b0010; zgnt[7] = 4'b0000;
        for (int c = 0; c < 8; c++) begin
            tick();
            check($sformatf("zero_x%0d", c),   32'(ifc0.X),   32'(zx[c]));
            check($sformatf("zero_gnt%0d", c), 32'(ifc0.Gnt), 32'(zgnt[c]));
        end
        ifc0.Req = '0;

`ifdef LASER_ARB_ABORT_EN
        // Abort in the second FIRE cycle: laser drops next edge, no Done, full cooldown, turn is lost.
        do_reset();
        ifc.Req = 4'b0001;
        tick();
        ifc.Req = '0;
        check("abort_fire0_x", 32'(ifc.X), 32'd1);
        tick();
        check("abort_fire1_x", 32'(ifc.X), 32'd1);
        set_abort(1'b1);
        tick();
        set_abort(1'b0);
        check_out("abort_cool0", '{1'b0, 4'b0000, 1'b1, 1'b0}, ifc.X, ifc.Gnt, ifc.Busy, ifc.Done);
        tick();
        check_out("abort_cool1", '{1'b0, 4'b0000, 1'b1, 1'b0}, ifc.X, ifc.Gnt, ifc.Busy, ifc.Done);
        tick();
        check_out("abort_idle", '{1'b0, 4'b0000, 1'b0, 1'b0}, ifc.X, ifc.Gnt, ifc.Busy, ifc.Done);
        ifc.Req = 4'b0011;
        tick();
        check("abort_next_gnt", 32'(ifc.Gnt), 32'(4'b0010));
`endif

        // Reset during the second FIRE cycle restores IDLE and requester 0's priority.
        do_reset();
        ifc.Req = 4'b0100;
        tick();
        ifc.Req = '0;
        tick();
        check("rstmid_fire1_gnt", 32'(ifc.Gnt), 32'(4'b0100));
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        check_out("rstmid_idle", '{1'b0, 4'b0000, 1'b0, 1'b0}, ifc.X, ifc.Gnt, ifc.Busy, ifc.Done);
        ifc.Req = 4'b1001;
        tick();
        check("rstmid_gnt", 32'(ifc.Gnt), 32'(4'b0001));

        // Random traffic on both instances against the timeline model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            Rst = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 2) == 0) ifc.Req  = N'($urandom & $urandom);
            if ($urandom_range(0, 2) == 0) ifc0.Req = N'($urandom & $urandom);
`ifdef LASER_ARB_ABORT_EN
            ifc.Abort = ($urandom_range(0, 5) == 0);
`endif
            tick();
            check_out("rand_main", model_out(m_main), ifc.X,  ifc.Gnt,  ifc.Busy,  ifc.Done);
            check_out("rand_zero", model_out(m_zero), ifc0.X, ifc0.Gnt, ifc0.Busy, ifc0.Done);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
